// File: rtl/ow_pkg.sv
// rtl/ow_pkg.sv - shared types and constants for the 1-Wire byte sequencer
package ow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_ISSUE,
    ST_BIT_WAIT,
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_DONE
  } ow_state_e;

  localparam logic OW_OP_WRITE = 1'b0;
  localparam logic OW_OP_RESET = 1'b1;

  // Bit-level transmitter low times, in clk cycles
  localparam int OW_T_LOW1 = 6;
  localparam int OW_T_LOW0 = 60;

endpackage

// File: rtl/ow_byte_sequencer_if.sv
// rtl/ow_byte_sequencer_if.sv - host command, transmitter and bus signals of the sequencer
interface ow_byte_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_data;
  logic       tx_bit;
  logic       tx_ready;
  logic       rst_low;
  logic       bus_in;
  logic       busy;
  logic       done;
  logic       presence;

  modport master (
    output cmd_valid, cmd_op, cmd_data, bus_in,
    input  cmd_ready, tx_bit, tx_ready, rst_low, busy, done, presence
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, bus_in,
    output cmd_ready, tx_bit, tx_ready, rst_low, busy, done, presence
  );

endinterface

// File: rtl/ow_sync2.sv
// rtl/ow_sync2.sv - two-flop synchroniser, resets to 1 (idle bus level)
module ow_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/ow_byte_sequencer.sv
// rtl/ow_byte_sequencer.sv - 1-Wire command sequencer: LSB-first byte writes and reset/presence
module ow_byte_sequencer
  import ow_pkg::*;
#(
  parameter int SLOT_CYCLES            = 70,
  parameter int RESET_LOW_CYCLES       = 480,
  parameter int PRESENCE_SAMPLE_CYCLES = 70,
  parameter int RESET_TOTAL_CYCLES     = 960,
  parameter int CNT_W                  = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ow_byte_sequencer_if.slave bus_if
);

  localparam logic [CNT_W-1:0] SLOT_LOAD     = CNT_W'(SLOT_CYCLES - 2);
  localparam logic [CNT_W-1:0] RST_LOW_LOAD  = CNT_W'(RESET_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LOAD = CNT_W'(RESET_TOTAL_CYCLES - RESET_LOW_CYCLES - 1);
  // Counter value in RST_WAIT that is PRESENCE_SAMPLE_CYCLES after bus release
  localparam logic [CNT_W-1:0] PRES_POINT    =
    CNT_W'(RESET_TOTAL_CYCLES - RESET_LOW_CYCLES - 1 - PRESENCE_SAMPLE_CYCLES);

  if (SLOT_CYCLES < OW_T_LOW0 + 2 || SLOT_CYCLES <= OW_T_LOW1) begin : g_bad_slot
    $error("SLOT_CYCLES too short for the transmitter write-0 slot");
  end
  if (RESET_TOTAL_CYCLES <= RESET_LOW_CYCLES + PRESENCE_SAMPLE_CYCLES) begin : g_bad_reset
    $error("RESET_TOTAL_CYCLES must exceed reset low plus presence sample time");
  end

  ow_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             presence_q, presence_d;
  logic             bus_sync;

  ow_sync2 u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus_if.bus_in),
    .q_o    (bus_sync)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      presence_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      presence_q <= presence_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    presence_d = presence_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.cmd_valid) begin
          if (bus_if.cmd_op == OW_OP_RESET) begin
            cnt_d   = RST_LOW_LOAD;
            state_d = ST_RST_LOW;
          end else begin
            shift_d = bus_if.cmd_data;
            idx_d   = 3'd0;
            state_d = ST_BIT_ISSUE;
          end
        end
      end
      ST_BIT_ISSUE: begin
        cnt_d   = SLOT_LOAD;
        state_d = ST_BIT_WAIT;
      end
      ST_BIT_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          state_d = ST_BIT_ISSUE;
        end
      end
      ST_RST_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = RST_WAIT_LOAD;
          state_d = ST_RST_WAIT;
        end
      end
      ST_RST_WAIT: begin
        if (cnt_q == PRES_POINT) begin
          presence_d = ~bus_sync;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once
  assign bus_if.cmd_ready = (state_q == ST_IDLE);
  assign bus_if.busy      = (state_q != ST_IDLE);
  assign bus_if.done      = (state_q == ST_DONE);
  assign bus_if.tx_ready  = (state_q == ST_BIT_ISSUE);
  assign bus_if.tx_bit    = shift_q[0] & ((state_q == ST_BIT_ISSUE) || (state_q == ST_BIT_WAIT));
  assign bus_if.rst_low   = (state_q == ST_RST_LOW);
  assign bus_if.presence  = presence_q;

endmodule

// File: tb/tb_ow_byte_sequencer.sv
// tb/tb_ow_byte_sequencer.sv - directed self-checking bench for ow_byte_sequencer
module tb_ow_byte_sequencer;
  import ow_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;

  ow_byte_sequencer_if sb ();

  ow_byte_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_if (sb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at the negedge of cycle 1 after acceptance; leaves at cycle 562
  task automatic watch_write(input string tag, input logic [7:0] exp_byte);
    int   nrdy = 0;
    int   ndone = 0;
    int   done_cyc = 0;
    int   clash = 0;
    int   rdy_cyc[8] = '{default: 0};
    logic bits[8] = '{default: 1'bx};
    for (int c = 1; c <= 561; c++) begin
      if (sb.tx_ready) begin
        if (nrdy < 8) begin
          rdy_cyc[nrdy] = c;
          bits[nrdy]    = sb.tx_bit;
        end
        nrdy++;
      end
      if (sb.done) begin
        ndone++;
        done_cyc = c;
      end
      if (sb.tx_ready && sb.rst_low) clash++;
      step();
    end
    chk({tag, " slot_count"}, nrdy, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s slot%0d_cycle", tag, k), rdy_cyc[k], 1 + 70 * k);
      chk($sformatf("%s slot%0d_bit", tag, k), {31'd0, bits[k]}, {31'd0, exp_byte[k]});
    end
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " done_cycle"}, done_cyc, 561);
    chk({tag, " txready_during_rstlow"}, clash, 0);
    chk({tag, " idle_after"}, {31'd0, sb.busy}, 0);
    chk({tag, " ready_after"}, {31'd0, sb.cmd_ready}, 1);
  endtask

  // Device model pulls the bus low from release+20 to release+120 when pull=1
  task automatic watch_reset(input string tag, input logic pull, input logic exp_pres);
    int nlow = 0;
    int first = 0;
    int last = 0;
    int ndone = 0;
    int done_cyc = 0;
    int clash = 0;
    for (int c = 1; c <= 961; c++) begin
      sb.bus_in = !(sb.rst_low || (pull && c >= 501 && c <= 601));
      if (sb.rst_low) begin
        nlow++;
        if (first == 0) first = c;
        last = c;
      end
      if (sb.done) begin
        ndone++;
        done_cyc = c;
      end
      if (sb.tx_ready && sb.rst_low) clash++;
      step();
    end
    sb.bus_in = 1'b1;
    chk({tag, " rstlow_cycles"}, nlow, 480);
    chk({tag, " rstlow_first"}, first, 1);
    chk({tag, " rstlow_last"}, last, 480);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " done_cycle"}, done_cyc, 961);
    chk({tag, " txready_during_rstlow"}, clash, 0);
    chk({tag, " presence"}, {31'd0, sb.presence}, {31'd0, exp_pres});
    chk({tag, " idle_after"}, {31'd0, sb.busy}, 0);
  endtask

  task automatic issue(input logic op, input logic [7:0] data);
    sb.cmd_valid = 1'b1;
    sb.cmd_op    = op;
    sb.cmd_data  = data;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, {31'd0, sb.cmd_ready}, 1);
    chk({tag, " busy"}, {31'd0, sb.busy}, 0);
    chk({tag, " rst_low"}, {31'd0, sb.rst_low}, 0);
    chk({tag, " tx_ready"}, {31'd0, sb.tx_ready}, 0);
    chk({tag, " tx_bit"}, {31'd0, sb.tx_bit}, 0);
    chk({tag, " done"}, {31'd0, sb.done}, 0);
    chk({tag, " presence"}, {31'd0, sb.presence}, 0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    sb.cmd_valid = 1'b0;
    sb.cmd_op    = OW_OP_WRITE;
    sb.cmd_data  = 8'h00;
    sb.bus_in    = 1'b1;
    @(negedge clk);

    // Command offered while held in reset must not be taken
    sb.cmd_valid = 1'b1;
    sb.cmd_data  = 8'hA5;
    step();
    step();
    check_reset_outputs("in_reset");
    sb.cmd_valid = 1'b0;
    rst_ni = 1'b1;
    step();
    chk("post_reset busy", {31'd0, sb.busy}, 0);
    chk("post_reset tx_ready", {31'd0, sb.tx_ready}, 0);

    // WRITE_BYTE 0xA5, data changed while busy
    issue(OW_OP_WRITE, 8'hA5);
    sb.cmd_valid = 1'b0;
    sb.cmd_data  = 8'h5A;
    watch_write("wr_a5", 8'hA5);

    // BUS_RESET with an answering device, then with a silent bus
    issue(OW_OP_RESET, 8'h00);
    sb.cmd_valid = 1'b0;
    watch_reset("rst_pres", 1'b1, 1'b1);
    issue(OW_OP_RESET, 8'h00);
    sb.cmd_valid = 1'b0;
    watch_reset("rst_nopres", 1'b0, 1'b0);

    issue(OW_OP_WRITE, 8'hFF);
    sb.cmd_valid = 1'b0;
    watch_write("wr_ff", 8'hFF);
    chk("wr_ff presence_kept", {31'd0, sb.presence}, 0);

    // Back-to-back with cmd_valid held; second byte presented while first is busy
    issue(OW_OP_WRITE, 8'h01);
    sb.cmd_data = 8'h80;
    watch_write("b2b_first", 8'h01);
    step();
    sb.cmd_valid = 1'b0;
    chk("b2b_second accepted", {31'd0, sb.tx_ready}, 1);
    watch_write("b2b_second", 8'h80);

    // Async reset in the middle of bit 3 (issued at cycle 211)
    issue(OW_OP_WRITE, 8'h5A);
    sb.cmd_valid = 1'b0;
    for (int c = 1; c < 230; c++) step();
    chk("midbyte bit3", {31'd0, sb.tx_bit}, 1);
    chk("midbyte busy", {31'd0, sb.busy}, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midbyte_rst");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midbyte_rst no_done", {31'd0, sb.done}, 0);
    end
    rst_ni = 1'b1;
    step();

    // Async reset while the bus is held low
    issue(OW_OP_RESET, 8'h00);
    sb.cmd_valid = 1'b0;
    for (int c = 1; c < 100; c++) step();
    chk("midrst rst_low", {31'd0, sb.rst_low}, 1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst_rst");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_rst no_done", {31'd0, sb.done}, 0);
    end
    rst_ni = 1'b1;
    step();

    issue(OW_OP_WRITE, 8'h3C);
    sb.cmd_valid = 1'b0;
    watch_write("wr_3c_after_rst", 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
